bnn_seq_ctrl: RTL and testbench

BNN_SEQ_CTRL -- requirements
Module: bnn_seq_ctrl

---
 rtl/bnn_pkg.sv | 32 +++
 rtl/bnn_xnor_popcount.sv | 24 ++
 rtl/bnn_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_bnn_seq_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared constants, state encoding and reset defaults for the BNN sequencer.
package bnn_pkg;

    localparam int unsigned NUM_NEURONS = 4;
    localparam int unsigned NUM_WEIGHTS = 6;
    localparam int unsigned SUM_W       = 3;
    localparam int unsigned CFG_W       = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CFG  = 2'd1,
        ST_EVAL = 2'd2,
        ST_OUT  = 2'd3
    } bnn_state_t;

    localparam logic [NUM_WEIGHTS-1:0] DEF_WEIGHT0 = 6'b111000;
    localparam logic [NUM_WEIGHTS-1:0] DEF_WEIGHT1 = 6'b000111;
    localparam logic [NUM_WEIGHTS-1:0] DEF_WEIGHT2 = 6'b001100;
    localparam logic [NUM_WEIGHTS-1:0] DEF_WEIGHT3 = 6'b110011;
    localparam logic [SUM_W-1:0]       DEF_THR     = 3'd2;

    // Default weight for neuron n; larger arrays repeat the four base patterns.
    function automatic logic [NUM_WEIGHTS-1:0] default_weight(input int unsigned n);
        case (n % 4)
            0:       return DEF_WEIGHT0;
            1:       return DEF_WEIGHT1;
            2:       return DEF_WEIGHT2;
            default: return DEF_WEIGHT3;
        endcase
    endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational XNOR-popcount: number of positions where weight and data agree.
module bnn_xnor_popcount
    import bnn_pkg::*;
#(
    parameter int unsigned NUM_WEIGHTS = bnn_pkg::NUM_WEIGHTS,
    parameter int unsigned SUM_W       = bnn_pkg::SUM_W
) (
    input  logic [NUM_WEIGHTS-1:0] weight_i,
    input  logic [NUM_WEIGHTS-1:0] data_i,
    output logic [SUM_W-1:0]       sum_o
);

    logic [NUM_WEIGHTS-1:0] match;

    // Count agreeing bit positions.
    always_comb begin
        match = ~(weight_i ^ data_i);
        sum_o = '0;
        for (int unsigned i = 0; i < NUM_WEIGHTS; i++) begin
            sum_o = sum_o + SUM_W'(match[i]);
        end
    end

endmodule

// File: rtl/bnn_seq_ctrl.sv
// Sequential binary-neural-network controller: reconfigurable weights and
// thresholds, one neuron evaluated per cycle through a shared popcount unit.
module bnn_seq_ctrl
    import bnn_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = bnn_pkg::NUM_NEURONS,
    parameter int unsigned NUM_WEIGHTS = bnn_pkg::NUM_WEIGHTS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_start,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CFG_W-1:0]       cfg_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_WEIGHTS-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_NEURONS-1:0] out_data,
    output logic [1:0]             state_dbg
);

    localparam int unsigned      IDX_W    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    bnn_state_t             state_q, state_d;
    logic [IDX_W-1:0]       cfg_idx_q, cfg_idx_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_WEIGHTS-1:0] in_reg_q, in_reg_d;
    logic [NUM_NEURONS-1:0] out_data_q, out_data_d;
    logic [NUM_WEIGHTS-1:0] weight_q [NUM_NEURONS];
    logic [SUM_W-1:0]       thr_q    [NUM_NEURONS];
    logic                   cfg_we;
    logic [SUM_W-1:0]       pop_sum;
    logic                   neuron_fire;

    bnn_xnor_popcount #(
        .NUM_WEIGHTS (NUM_WEIGHTS),
        .SUM_W       (SUM_W)
    ) u_popcount (
        .weight_i (weight_q[idx_q]),
        .data_i   (in_reg_q),
        .sum_o    (pop_sum)
    );

    // Unsigned compare: threshold 0 always fires, threshold 7 never can.
    assign neuron_fire = (pop_sum >= thr_q[idx_q]);

    // Next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        cfg_idx_d  = cfg_idx_q;
        idx_d      = idx_q;
        in_reg_d   = in_reg_q;
        out_data_d = out_data_q;
        cfg_we     = 1'b0;
        in_ready   = 1'b0;
        cfg_ready  = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = ~cfg_start;
                if (cfg_start) begin
                    state_d   = ST_CFG;
                    cfg_idx_d = '0;
                end else if (in_valid) begin
                    in_reg_d = in_data;
                    idx_d    = '0;
                    state_d  = ST_EVAL;
                end
            end
            ST_CFG: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    cfg_we    = 1'b1;
                    cfg_idx_d = cfg_idx_q + IDX_W'(1);
                    if (cfg_idx_q == LAST_IDX) begin
                        cfg_idx_d = '0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_EVAL: begin
                out_data_d[idx_q] = neuron_fire;
                idx_d             = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cfg_idx_q  <= '0;
            idx_q      <= '0;
            in_reg_q   <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cfg_idx_q  <= cfg_idx_d;
            idx_q      <= idx_d;
            in_reg_q   <= in_reg_d;
            out_data_q <= out_data_d;
        end
    end

    // Configuration memory; written only by CFG handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                weight_q[i] <= NUM_WEIGHTS'(default_weight(i));
                thr_q[i]    <= DEF_THR;
            end
        end else if (cfg_we) begin
            weight_q[cfg_idx_q] <= cfg_data[NUM_WEIGHTS-1:0];
            thr_q[cfg_idx_q]    <= cfg_data[CFG_W-1 -: SUM_W];
        end
    end

    assign out_data  = out_data_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Randomized self-checking bench for bnn_seq_ctrl with a transaction-level model.
module tb_bnn_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [8:0] cfg_data = '0;
    logic       in_valid = 1'b0;
    logic [5:0] in_data = '0;
    logic       out_ready = 1'b0;
    logic       cfg_ready, in_ready, out_valid;
    logic [3:0] out_data;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    bnn_seq_ctrl #(
        .NUM_NEURONS (4),
        .NUM_WEIGHTS (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .state_dbg (state_dbg)
    );

    int total = 0;
    int bad   = 0;

    // Model: configuration contents and last delivered result.
    logic [5:0] m_w [4];
    logic [2:0] m_t [4];
    logic [3:0] m_last;

    // Expected DUT outputs for the current cycle.
    logic       chk_en = 1'b0;
    logic [1:0] e_state;
    logic       e_in_ready, e_cfg_ready, e_out_valid;
    logic [3:0] e_out_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("state_dbg", 32'(state_dbg), 32'(e_state));
            check("in_ready",  32'(in_ready),  32'(e_in_ready));
            check("cfg_ready", 32'(cfg_ready), 32'(e_cfg_ready));
            check("out_valid", 32'(out_valid), 32'(e_out_valid));
            check("out_data",  32'(out_data),  32'(e_out_data));
        end
    end

    function automatic logic [3:0] predict(input logic [5:0] x);
        logic [3:0] r;
        for (int n = 0; n < 4; n++) begin
            r[n] = ($countones(~(x ^ m_w[n])) >= int'(m_t[n]));
        end
        return r;
    endfunction

    task automatic model_defaults();
        m_w[0] = 6'b111000; m_w[1] = 6'b000111;
        m_w[2] = 6'b001100; m_w[3] = 6'b110011;
        for (int n = 0; n < 4; n++) m_t[n] = 3'd2;
        m_last = 4'b0000;
    endtask

    task automatic set_exp(input logic [1:0] st, input logic ir, input logic cr,
                           input logic ov, input logic [3:0] od);
        e_state = st; e_in_ready = ir; e_cfg_ready = cr; e_out_valid = ov; e_out_data = od;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int ncyc);
        rst_n = 1'b0;
        cfg_start = 1'b0; cfg_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        model_defaults();
        set_exp(2'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
        chk_en = 1'b1;
        repeat (ncyc) step();
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        cfg_start = 1'b0; cfg_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_exp(2'd0, 1'b1, 1'b0, 1'b0, m_last);
        repeat (n) step();
    endtask

    // Full inference: accept, four EVAL cycles, OUT held for 'hold' cycles.
    task automatic infer(input logic [5:0] x, input int hold, input logic stray,
                         output logic [3:0] got);
        logic [3:0] exp, mask;
        in_valid = 1'b1; in_data = x;
        set_exp(2'd0, 1'b1, 1'b0, 1'b0, m_last);
        step();
        in_valid = 1'b0; in_data = 6'($urandom);
        exp = predict(x);
        for (int k = 0; k < 4; k++) begin
            mask = 4'((1 << k) - 1);
            cfg_start = stray & 1'($urandom);
            set_exp(2'd2, 1'b0, 1'b0, 1'b0, (exp & mask) | (m_last & ~mask));
            step();
        end
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0; in_valid = stray; cfg_start = stray & 1'($urandom);
            set_exp(2'd3, 1'b0, 1'b0, 1'b1, exp);
            step();
        end
        out_ready = 1'b1; in_valid = stray; cfg_start = 1'b0;
        set_exp(2'd3, 1'b0, 1'b0, 1'b1, exp);
        got = out_data;
        step();
        out_ready = 1'b0; in_valid = 1'b0; cfg_start = 1'b0;
        m_last = exp;
        set_exp(2'd0, 1'b1, 1'b0, 1'b0, m_last);
    endtask

    // Reconfiguration: load nwords words (nwords < 4 leaves the DUT in CFG).
    task automatic configure(input logic [23:0] wv, input logic [11:0] tv,
                             input int nwords, input logic with_in);
        cfg_start = 1'b1; in_valid = with_in; in_data = 6'($urandom);
        set_exp(2'd0, 1'b0, 1'b0, 1'b0, m_last);
        step();
        cfg_start = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < nwords; i++) begin
            repeat ($urandom_range(0, 2)) begin
                cfg_valid = 1'b0; cfg_data = 9'($urandom);
                in_valid = 1'($urandom); cfg_start = 1'($urandom);
                set_exp(2'd1, 1'b0, 1'b1, 1'b0, m_last);
                step();
            end
            cfg_valid = 1'b1; cfg_data = {tv[3*i +: 3], wv[6*i +: 6]};
            in_valid = 1'($urandom); cfg_start = 1'($urandom);
            set_exp(2'd1, 1'b0, 1'b1, 1'b0, m_last);
            step();
            m_w[i] = wv[6*i +: 6];
            m_t[i] = tv[3*i +: 3];
        end
        cfg_valid = 1'b0; cfg_start = 1'b0; in_valid = 1'b0;
        if (nwords >= 4) set_exp(2'd0, 1'b1, 1'b0, 1'b0, m_last);
        else             set_exp(2'd1, 1'b0, 1'b1, 1'b0, m_last);
    endtask

    logic [3:0] got;

    initial begin
        model_defaults();
        set_exp(2'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
        #1;
        apply_reset(3);
        idle(1);

        // Default configuration.
        check("model_pin_default", 32'(predict(6'b111000)), 32'h0000000d);
        infer(6'b111000, 0, 1'b0, got);
        check("default_111000", 32'(got), 32'h0000000d);

        // All-zero weights, threshold 6.
        configure(24'h000000, {4{3'd6}}, 4, 1'b0);
        check("model_pin_thr6", 32'(predict(6'b000000)), 32'h0000000f);
        infer(6'b000000, 0, 1'b0, got);
        check("thr6_all_match", 32'(got), 32'h0000000f);
        infer(6'b000001, 1, 1'b0, got);
        check("thr6_one_miss", 32'(got), 32'h00000000);

        // Thresholds 0,7,0,7: result independent of input and weights.
        configure(24'($urandom), {3'd7, 3'd0, 3'd7, 3'd0}, 4, 1'b0);
        infer(6'($urandom), 3, 1'b1, got);
        check("thr_0707_held", 32'(got), 32'h00000005);
        infer(6'($urandom), 0, 1'b0, got);
        check("thr_0707_b", 32'(got), 32'h00000005);

        // cfg_start wins over a simultaneous in_valid.
        configure(24'($urandom), 12'($urandom), 4, 1'b1);
        idle(1);

        // Randomized mix of inferences, reconfigurations and idle gaps.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0:       configure(24'($urandom), 12'($urandom), 4, 1'($urandom));
                1:       idle($urandom_range(1, 3));
                default: infer(6'($urandom), $urandom_range(0, 3), 1'($urandom), got);
            endcase
        end

        // Reset during EVAL at neuron index 2 restores defaults.
        in_valid = 1'b1; in_data = 6'b010101;
        set_exp(2'd0, 1'b1, 1'b0, 1'b0, m_last);
        step();
        in_valid = 1'b0;
        begin
            logic [3:0] ex, mk;
            ex = predict(6'b010101);
            for (int k = 0; k < 2; k++) begin
                mk = 4'((1 << k) - 1);
                set_exp(2'd2, 1'b0, 1'b0, 1'b0, (ex & mk) | (m_last & ~mk));
                step();
            end
        end
        apply_reset(2);
        idle(2);
        infer(6'b111000, 0, 1'b0, got);
        check("after_eval_reset", 32'(got), 32'h0000000d);

        // Reset during partial configuration discards it.
        configure(24'h000000, {4{3'd7}}, 2, 1'b0);
        apply_reset(1);
        idle(1);
        infer(6'b111000, 2, 1'b0, got);
        check("after_cfg_reset", 32'(got), 32'h0000000d);
        idle(2);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
